// File: rtl/alu_sequencer.sv
// Microcoded sequencer driving a bus-based register file and ALU through IDLE/T1/T2/T3.
// Define ALU_SEQ_ILLEGAL_TRAP_EN to make illegal opcodes set a sticky Err instead of acting as NOP.
module alu_sequencer #(
   parameter int unsigned N    = 10,
   parameter int unsigned NREG = 8
) (
   input  logic            CLKb,
   input  logic            Rst,
   input  logic            Start,
   input  logic [N-1:0]    Instr,
   output logic [3:0]      FN,
   output logic            Ain,
   output logic            Gin,
   output logic            Gout,
   output logic [NREG-1:0] Rin,
   output logic [NREG-1:0] Rout,
   output logic            Extern,
   output logic            Busy,
   output logic            Done,
   output logic            Err
);

   typedef enum logic [1:0] {StIdle, StT1, StT2, StT3} state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [N-1:0]    r_ir;
   logic [3:0]      w_op;
   logic [2:0]      w_rx;
   logic [2:0]      w_ry;
   logic [NREG-1:0] w_rx_oh;
   logic [NREG-1:0] w_ry_oh;
   logic            w_is_load;
   logic            w_is_mov;
   logic            w_is_alu;
   logic            w_is_not;
   logic            w_illegal;
   logic            w_accept;

   assign w_op    = r_ir[9:6];
   assign w_rx    = r_ir[5:3];
   assign w_ry    = r_ir[2:0];
   assign w_rx_oh = NREG'(1) << w_rx;
   assign w_ry_oh = NREG'(1) << w_ry;

   always_comb begin
      w_is_load = 1'b0;
      w_is_mov  = 1'b0;
      w_is_alu  = 1'b0;
      w_is_not  = 1'b0;
      case (w_op)
         4'b0000: w_is_load = 1'b1;
         4'b0001: w_is_mov  = 1'b1;
         4'b0010, 4'b0011, 4'b0110, 4'b0111, 4'b1000: w_is_alu = 1'b1;
         4'b1001: w_is_not  = 1'b1;
         default: ;
      endcase
   end

   assign w_illegal = !(w_is_load || w_is_mov || w_is_alu || w_is_not);

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
   logic r_err;

   always_ff @(posedge CLKb or posedge Rst) begin
      if (Rst) begin
         r_err <= 1'b0;
      end else if (r_state == StT1 && w_illegal) begin
         r_err <= 1'b1;
      end
   end

   assign Err = r_err;
`else
   assign Err = 1'b0;
`endif

   // A trapped sequencer refuses new work until reset.
   assign w_accept = (r_state == StIdle) && Start && !Err;

   always_ff @(posedge CLKb or posedge Rst) begin
      if (Rst) begin
         r_state <= StIdle;
         r_ir    <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_ir <= Instr;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: if (w_accept) w_state_next = StT1;
         StT1:   w_state_next = (w_is_alu || w_is_not) ? StT2 : StIdle;
         StT2:   w_state_next = StT3;
         StT3:   w_state_next = StIdle;
      endcase
   end

   always_comb begin
      FN     = 4'b0000;
      Ain    = 1'b0;
      Gin    = 1'b0;
      Gout   = 1'b0;
      Rin    = '0;
      Rout   = '0;
      Extern = 1'b0;
      Done   = 1'b0;
      Busy   = (r_state != StIdle);
      unique case (r_state)
         StIdle: ;
         StT1: begin
            if (w_is_load) begin
               Extern = 1'b1;
               Rin    = w_rx_oh;
               Done   = 1'b1;
            end else if (w_is_mov) begin
               Rout = w_ry_oh;
               Rin  = w_rx_oh;
               Done = 1'b1;
            end else if (w_is_alu || w_is_not) begin
               Rout = w_rx_oh;
               Ain  = 1'b1;
            end else begin
`ifndef ALU_SEQ_ILLEGAL_TRAP_EN
               Done = w_illegal;
`endif
            end
         end
         StT2: begin
            Gin = 1'b1;
            if (w_is_not) begin
               FN = 4'b1001;
            end else begin
               FN   = w_op;
               Rout = w_ry_oh;
            end
         end
         StT3: begin
            Gout = 1'b1;
            Rin  = w_rx_oh;
            Done = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: expected per-cycle output vectors are queued as each
// instruction is issued and compared one per clock, #1 after the rising edge.
module tb_alu_sequencer;

   typedef struct packed {
      logic [3:0] fn;
      logic       ain;
      logic       gin;
      logic       gout;
      logic [7:0] rin;
      logic [7:0] rout;
      logic       ext;
      logic       busy;
      logic       done;
      logic       err;
   } out_t;

   logic       CLKb = 1'b0;
   logic       Rst  = 1'b1;
   logic       Start = 1'b0;
   logic [9:0] Instr = '0;
   logic [3:0] FN;
   logic       Ain, Gin, Gout, Extern, Busy, Done, Err;
   logic [7:0] Rin, Rout;

   out_t obs;
   out_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   logic m_err = 1'b0;

   assign obs = {FN, Ain, Gin, Gout, Rin, Rout, Extern, Busy, Done, Err};

   alu_sequencer #(.N(10), .NREG(8)) dut (
      .CLKb(CLKb), .Rst(Rst), .Start(Start), .Instr(Instr), .FN(FN), .Ain(Ain), .Gin(Gin),
      .Gout(Gout), .Rin(Rin), .Rout(Rout), .Extern(Extern), .Busy(Busy), .Done(Done), .Err(Err)
   );

   always #5 CLKb = ~CLKb;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] oh(input logic [2:0] idx);
      logic [7:0] v;
      v = 8'd0;
      v[idx] = 1'b1;
      return v;
   endfunction

   function automatic int n_phases(input logic [9:0] ins);
      case (ins[9:6])
         4'b0010, 4'b0011, 4'b0110, 4'b0111, 4'b1000, 4'b1001: return 3;
         default: return 1;
      endcase
   endfunction

   // Reference outputs for one cycle; phase 0 is an idle cycle.
   function automatic out_t exp_vec(input logic [9:0] ins, input int phase, input logic err);
      out_t       v;
      logic [3:0] op;
      v     = '0;
      v.err = err;
      op    = ins[9:6];
      if (phase == 0) return v;
      v.busy = 1'b1;
      case (op)
         4'b0000: begin v.ext = 1'b1; v.rin = oh(ins[5:3]); v.done = 1'b1; end
         4'b0001: begin v.rout = oh(ins[2:0]); v.rin = oh(ins[5:3]); v.done = 1'b1; end
         4'b0010, 4'b0011, 4'b0110, 4'b0111, 4'b1000, 4'b1001: begin
            if (phase == 1) begin
               v.rout = oh(ins[5:3]);
               v.ain  = 1'b1;
            end else if (phase == 2) begin
               v.gin  = 1'b1;
               v.fn   = op;
               v.rout = (op == 4'b1001) ? 8'd0 : oh(ins[2:0]);
            end else begin
               v.gout = 1'b1;
               v.rin  = oh(ins[5:3]);
               v.done = 1'b1;
            end
         end
         default: begin
`ifndef ALU_SEQ_ILLEGAL_TRAP_EN
            v.done = 1'b1;
`endif
         end
      endcase
      return v;
   endfunction

   task automatic push_instr(input logic [9:0] ins);
      for (int p = 1; p <= n_phases(ins); p++) sb.push_back(exp_vec(ins, p, m_err));
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      if (n_phases(ins) == 1 && ins[9:6] > 4'b0001) m_err = 1'b1;
`endif
   endtask

   task automatic push_idle(input int n);
      for (int i = 0; i < n; i++) sb.push_back(exp_vec(10'd0, 0, m_err));
   endtask

   task automatic step(input int n, input string tag);
      out_t e;
      for (int i = 0; i < n; i++) begin
         @(posedge CLKb);
         #1;
         if (sb.size() == 0) begin
            check_eq({tag, "_underflow"}, 32'(obs), 'x);
         end else begin
            e = sb.pop_front();
            check_eq(tag, 32'(obs), 32'(e));
         end
      end
   endtask

   task automatic run_instr(input logic [9:0] ins, input string tag);
      Start = 1'b1;
      Instr = ins;
      push_instr(ins);
      push_idle(1);
      step(1, tag);
      Start = 1'b0;
      step(n_phases(ins), tag);
   endtask

   logic [9:0] table_ins[8] = '{
      10'b0011_110_001, 10'b0110_000_111, 10'b0111_011_100, 10'b1000_010_101,
      10'b0010_101_101, 10'b0001_111_000, 10'b0000_111_000, 10'b1001_110_110
   };

   initial begin
      #1;
      check_eq("reset_outputs", 32'(obs), 32'd0);
      @(posedge CLKb);
      #1;
      Rst = 1'b0;

      run_instr(10'b0000_010_000, "load_r2");
      run_instr(10'b0010_001_011, "add_r1_r3");

      // Start stays high across an ADD; the MOV presented during T2 waits for IDLE.
      Start = 1'b1;
      Instr = 10'b0010_001_011;
      push_instr(10'b0010_001_011);
      push_idle(1);
      step(2, "b2b_add");
      Instr = 10'b0001_000_101;
      step(2, "b2b_add");
      push_instr(10'b0001_000_101);
      push_idle(1);
      step(1, "b2b_mov");
      Start = 1'b0;
      step(1, "b2b_mov");

      // Reset in T2 of SUB must blank outputs at once and stop the sequence.
      Start = 1'b1;
      Instr = 10'b0011_001_010;
      sb.push_back(exp_vec(10'b0011_001_010, 1, m_err));
      sb.push_back(exp_vec(10'b0011_001_010, 2, m_err));
      step(1, "sub_abort");
      Start = 1'b0;
      step(1, "sub_abort");
      Rst = 1'b1;
      #1;
      check_eq("rst_mid", 32'(obs), 32'd0);
      @(posedge CLKb);
      #1;
      check_eq("rst_hold", 32'(obs), 32'd0);
      Rst = 1'b0;
      push_idle(3);
      step(3, "post_abort");

      run_instr(10'b1001_100_000, "not_r4");
      foreach (table_ins[i]) run_instr(table_ins[i], $sformatf("tbl%0d", i));

      run_instr(10'b1111_001_010, "illegal");
      Start = 1'b1;
      Instr = 10'b0000_011_000;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      push_idle(2);
      step(2, "trap_ignore");
      Start = 1'b0;
      Rst = 1'b1;
      #1;
      m_err = 1'b0;
      check_eq("trap_clear", 32'(obs), 32'd0);
      @(posedge CLKb);
      #1;
      Rst = 1'b0;
`endif
      Start = 1'b0;
      run_instr(10'b0000_011_000, "recover_load");
      run_instr(10'b0100_000_000, "illegal_0100");

      check_eq("sb_drain", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
